// File: rtl/frame_stream_ctrl.sv
`timescale 1ns/1ps
// Purpose: frame-level gate between the CMOS capture stream and the video processor; whole frames
//          only, enable / single-shot control, optional warm-up skip, geometry check, frame count.
// Latency: 1 clk from in_* to out_*; frame_done/frame_cnt aligned with the registered outputs.
// Backpressure: none; the pixel stream cannot be stalled, frames are either forwarded or dropped.
// Ports: clk/rst (async active-high); enable, single_shot, err_clr control; in_vsync/href/clken/data
//        from capture; out_vsync/href/clken/data to processor; busy, frame_done, frame_cnt,
//        err_hsize, err_vsize status.
module frame_stream_ctrl #(
  parameter logic VSYNC_VALID = 1'b1,
  parameter int   IMG_HDISP   = 16,
  parameter int   IMG_VDISP   = 4,
  parameter int   SKIP_FRAMES = 0,
  parameter int   CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        single_shot,
  input  logic        err_clr,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_clken,
  input  logic [15:0] in_data,
  output logic        out_vsync,
  output logic        out_href,
  output logic        out_clken,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        err_hsize,
  output logic        err_vsize
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_SKIP   = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HDISP     = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] VDISP     = CNT_W'(IMG_VDISP);
  localparam logic [7:0]       SKIP_INIT = 8'(SKIP_FRAMES);

  logic [1:0]       state, state_nxt;
  logic             oneshot, oneshot_nxt;
  logic [7:0]       skip_cnt, skip_cnt_nxt;
  logic             done_nxt;
  logic             vsync_d, href_d;
  logic             se, href_fall, gate;
  logic [CNT_W-1:0] pix_cnt, line_cnt, line_cnt_inc;
  logic             seen_se, hsize_bad, vsize_bad;

  // vsync_d resets to the active level so a vsync already asserted at release is not an edge.
  assign se        = (in_vsync == VSYNC_VALID) && (vsync_d != VSYNC_VALID);
  assign href_fall = href_d && !in_href;
  assign busy      = (state != ST_IDLE);
  // Decide on the next state so the SE cycle opening a stream is forwarded and the closing one is not.
  assign gate      = (state_nxt == ST_STREAM);

  always_comb begin
    state_nxt    = state;
    oneshot_nxt  = oneshot;
    skip_cnt_nxt = skip_cnt;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt   = ST_SYNC;
          oneshot_nxt = 1'b0;
        end else if (single_shot) begin
          state_nxt   = ST_SYNC;
          oneshot_nxt = 1'b1;
        end
      end
      ST_SYNC: begin
        if (se) begin
          if (SKIP_FRAMES == 0) begin
            state_nxt = ST_STREAM;
          end else begin
            state_nxt    = ST_SKIP;
            skip_cnt_nxt = SKIP_INIT;
          end
        end else if (!enable && !oneshot) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (se) begin
          if (skip_cnt == 8'd1) state_nxt = ST_STREAM;
          else                  skip_cnt_nxt = skip_cnt - 8'd1;
        end else if (!enable && !oneshot) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        // Enable is only re-examined at the frame boundary, so a frame is never cut short.
        if (se) begin
          done_nxt = 1'b1;
          if (oneshot || !enable) state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // A line ending on the SE cycle still belongs to the frame being closed.
  assign line_cnt_inc = (href_fall && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;
  assign hsize_bad    = busy && href_fall && (pix_cnt != HDISP);
  assign vsize_bad    = busy && se && seen_se && (line_cnt_inc != VDISP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      oneshot    <= 1'b0;
      skip_cnt   <= 8'd0;
      vsync_d    <= VSYNC_VALID;
      href_d     <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      seen_se    <= 1'b0;
      err_hsize  <= 1'b0;
      err_vsize  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      out_vsync  <= ~VSYNC_VALID;
      out_href   <= 1'b0;
      out_clken  <= 1'b0;
      out_data   <= 16'd0;
    end else begin
      state    <= state_nxt;
      oneshot  <= oneshot_nxt;
      skip_cnt <= skip_cnt_nxt;
      vsync_d  <= in_vsync;
      href_d   <= in_href;

      if (!busy) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        seen_se  <= 1'b0;
      end else begin
        if (href_fall)
          pix_cnt <= '0;
        else if (in_href && in_clken && pix_cnt != CNT_MAX)
          pix_cnt <= pix_cnt + CNT_W'(1);
        if (se) begin
          line_cnt <= '0;
          seen_se  <= 1'b1;
        end else begin
          line_cnt <= line_cnt_inc;
        end
      end

      // A fresh error beats a simultaneous clear.
      if (hsize_bad)    err_hsize <= 1'b1;
      else if (err_clr) err_hsize <= 1'b0;
      if (vsize_bad)    err_vsize <= 1'b1;
      else if (err_clr) err_vsize <= 1'b0;

      frame_done <= done_nxt;
      if (done_nxt) frame_cnt <= frame_cnt + 8'd1;

      out_vsync <= gate ? in_vsync : ~VSYNC_VALID;
      out_href  <= gate & in_href;
      out_clken <= gate & in_clken;
      out_data  <= gate ? in_data : 16'd0;
    end
  end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
`timescale 1ns/1ps
module tb_frame_stream_ctrl;
  localparam int HD = 16;
  localparam int VD = 4;
  localparam int SAT = 2047;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, single_shot, err_clr;
  logic        in_vsync, in_href, in_clken;
  logic [15:0] in_data;

  logic [1:0]  ovs, ohr, ock, bsy, fdone, ehs, evs;
  logic [15:0] odat0, odat1;
  logic [7:0]  fcnt0, fcnt1;

  int errors = 0;
  int checks = 0;

  // Frame-level reference model, one slot per instance (0: no skip, 1: skip 2 frames).
  bit m_vd [2], m_hd [2], m_arm [2], m_cont [2], m_str [2];
  bit m_seen [2], m_eh [2], m_ev [2], m_done [2];
  int m_skip [2], m_pix [2], m_lines [2], m_cnt [2];
  int ck_cnt [2], done_cnt [2];

  always #5 clk = ~clk;

  frame_stream_ctrl #(.SKIP_FRAMES(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot), .err_clr(err_clr),
    .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken), .in_data(in_data),
    .out_vsync(ovs[0]), .out_href(ohr[0]), .out_clken(ock[0]), .out_data(odat0),
    .busy(bsy[0]), .frame_done(fdone[0]), .frame_cnt(fcnt0),
    .err_hsize(ehs[0]), .err_vsize(evs[0]));

  frame_stream_ctrl #(.SKIP_FRAMES(2)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot), .err_clr(err_clr),
    .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken), .in_data(in_data),
    .out_vsync(ovs[1]), .out_href(ohr[1]), .out_clken(ock[1]), .out_data(odat1),
    .busy(bsy[1]), .frame_done(fdone[1]), .frame_cnt(fcnt1),
    .err_hsize(ehs[1]), .err_vsize(evs[1]));

  function automatic logic [30:0] obs_vec(input int k);
    if (k == 0) return {ovs[0], ohr[0], ock[0], odat0, bsy[0], fdone[0], fcnt0, ehs[0], evs[0]};
    else        return {ovs[1], ohr[1], ock[1], odat1, bsy[1], fdone[1], fcnt1, ehs[1], evs[1]};
  endfunction

  task automatic check(input string tag, input logic [30:0] o, input logic [30:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset(input int k);
    m_vd[k] = 1'b1; m_hd[k] = 1'b0; m_arm[k] = 1'b0; m_cont[k] = 1'b0; m_str[k] = 1'b0;
    m_seen[k] = 1'b0; m_eh[k] = 1'b0; m_ev[k] = 1'b0; m_done[k] = 1'b0;
    m_skip[k] = 0; m_pix[k] = 0; m_lines[k] = 0; m_cnt[k] = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven; returns expected outputs.
  task automatic model_step(input int k, output logic [30:0] ex);
    bit se, hfall, eh, ev, gate;
    int lines_inc;
    int skip_frames;
    skip_frames = (k == 1) ? 2 : 0;
    if (rst) begin
      model_reset(k);
      ex = '0;
      return;
    end
    se = in_vsync && !m_vd[k];
    hfall = m_hd[k] && !in_href;
    eh = 1'b0;
    ev = 1'b0;
    if (!m_arm[k]) begin
      m_pix[k] = 0; m_lines[k] = 0; m_seen[k] = 1'b0;
    end else begin
      if (hfall) begin
        eh = (m_pix[k] != HD);
        m_pix[k] = 0;
      end else if (in_href && in_clken && m_pix[k] < SAT) begin
        m_pix[k]++;
      end
      lines_inc = (hfall && m_lines[k] < SAT) ? m_lines[k] + 1 : m_lines[k];
      if (se) begin
        ev = m_seen[k] && (lines_inc != VD);
        m_lines[k] = 0;
        m_seen[k] = 1'b1;
      end else begin
        m_lines[k] = lines_inc;
      end
    end
    m_eh[k] = eh ? 1'b1 : (err_clr ? 1'b0 : m_eh[k]);
    m_ev[k] = ev ? 1'b1 : (err_clr ? 1'b0 : m_ev[k]);

    m_done[k] = 1'b0;
    if (!m_arm[k]) begin
      if (enable || single_shot) begin
        m_arm[k] = 1'b1; m_cont[k] = enable; m_skip[k] = skip_frames; m_str[k] = 1'b0;
      end
    end else if (!m_str[k]) begin
      if (se) begin
        if (m_skip[k] == 0) m_str[k] = 1'b1;
        else                m_skip[k]--;
      end else if (!enable && m_cont[k]) begin
        m_arm[k] = 1'b0;
      end
    end else if (se) begin
      m_done[k] = 1'b1;
      m_cnt[k] = (m_cnt[k] + 1) % 256;
      if (!m_cont[k] || !enable) begin
        m_arm[k] = 1'b0;
        m_str[k] = 1'b0;
      end
    end
    gate = m_arm[k] && m_str[k];
    m_vd[k] = in_vsync;
    m_hd[k] = in_href;
    ex = {gate & in_vsync, gate & in_href, gate & in_clken, gate ? in_data : 16'h0,
          m_arm[k], m_done[k], 8'(m_cnt[k]), m_eh[k], m_ev[k]};
  endtask

  task automatic tick();
    logic [30:0] ex [2];
    for (int k = 0; k < 2; k++) model_step(k, ex[k]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      ck_cnt[k] += int'(ock[k]);
      done_cnt[k] += int'(fdone[k]);
      check(k == 0 ? "cycle_skip0" : "cycle_skip2", obs_vec(k), ex[k]);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      ck_cnt[k] = 0;
      done_cnt[k] = 0;
    end
  endtask

  // One frame: 3-cycle vsync, blank, lines with random clken gaps.
  // short_line: line with HD-1 pixels; drop_line: enable falls mid-line; clr_line: err_clr on
  // that line's href falling edge; rst_line: reset asserted mid-line; rel_in_vs: release reset
  // during this frame's vsync pulse.
  task automatic send_frame(input int nlines, input int short_line, input int drop_line,
                            input int clr_line, input int rst_line, input bit rel_in_vs);
    int want;
    int got;
    in_vsync = 1'b1; in_href = 1'b0; in_clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rel_in_vs && i == 1) rst = 1'b0;
      in_data = 16'($urandom);
      tick();
    end
    in_vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'($urandom);
      tick();
    end
    for (int l = 0; l < nlines; l++) begin
      want = (l == short_line) ? HD - 1 : HD;
      got = 0;
      in_href = 1'b1;
      while (got < want) begin
        in_clken = ($urandom_range(0, 3) != 0);
        in_data = 16'($urandom);
        if (l == drop_line && got == want / 2) enable = 1'b0;
        if (l == rst_line && got == want / 2 && !rst) begin
          rst = 1'b1;
          #1;
          check("rst_async_skip0", obs_vec(0), 31'd0);
          check("rst_async_skip2", obs_vec(1), 31'd0);
        end
        tick();
        if (in_clken) got++;
      end
      in_href = 1'b0;
      in_clken = 1'b0;
      for (int g = 0; g < 3; g++) begin
        in_data = 16'($urandom);
        err_clr = (l == clr_line && g == 0);
        tick();
      end
      err_clr = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      in_data = 16'($urandom);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; single_shot = 1'b0; err_clr = 1'b0;
    in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0; in_data = 16'h0;
    for (int k = 0; k < 2; k++) model_reset(k);
    clear_counts();
    repeat (3) tick();
    check("reset_state_skip0", obs_vec(0), 31'd0);
    check("reset_state_skip2", obs_vec(1), 31'd0);
    rst = 1'b0;
    tick();

    // Continuous streaming; the skip-2 instance drops frames 1-2 and forwards frame 3.
    enable = 1'b1;
    repeat (2) tick();
    clear_counts();
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t1_pix_fwd_skip0", 31'(ck_cnt[0]), 31'(2 * HD * VD));
    check("t3_pix_blocked_skip2", 31'(ck_cnt[1]), 31'd0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t1_frame_cnt", 31'(fcnt0), 31'd2);
    check("t1_done_pulses", 31'(done_cnt[0]), 31'd2);
    check("t1_errs", 31'({ehs[0], evs[0]}), 31'd0);
    check("t3_pix_fwd_skip2", 31'(ck_cnt[1]), 31'(HD * VD));
    enable = 1'b0;
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t1_busy_after", 31'(bsy), 31'd0);
    check("t1_frame_cnt_end", 31'(fcnt0), 31'd3);

    // Single shot: exactly one frame.
    single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    tick();
    clear_counts();
    repeat (3) send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t2_pix_fwd", 31'(ck_cnt[0]), 31'(HD * VD));
    check("t2_frame_cnt", 31'(fcnt0), 31'd4);
    check("t2_busy", 31'(bsy[0]), 31'd0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t2_frame_cnt_skip2", 31'(fcnt1), 31'd2);

    // Enable dropped mid-frame: frame completes, next one blocked.
    enable = 1'b1;
    tick();
    clear_counts();
    send_frame(VD, -1, 1, -1, -1, 1'b0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t4_done_once", 31'(done_cnt[0]), 31'd1);
    check("t4_pix_fwd", 31'(ck_cnt[0]), 31'(HD * VD));
    check("t4_frame_cnt", 31'(fcnt0), 31'd5);

    // Geometry errors and clear priority.
    enable = 1'b1;
    tick();
    send_frame(VD, 1, -1, -1, -1, 1'b0);
    check("t5_hsize_set", 31'({ehs[0], evs[0]}), 31'b10);
    send_frame(VD + 1, -1, -1, -1, -1, 1'b0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t5_vsize_set", 31'(evs[0]), 31'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_clear", 31'({ehs[0], evs[0]}), 31'd0);
    send_frame(VD, 2, -1, 2, -1, 1'b0);
    check("t5_new_err_wins", 31'(ehs[0]), 31'd1);

    // Reset mid-frame, released while vsync is already active.
    send_frame(VD, -1, -1, -1, 2, 1'b0);
    clear_counts();
    send_frame(VD, -1, -1, -1, -1, 1'b1);
    check("t6_no_fwd_after_rel", 31'(ck_cnt[0]), 31'd0);
    check("t6_errs_clear", 31'({ehs[0], evs[0]}), 31'd0);
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t6_fwd_next_se", 31'(ck_cnt[0]), 31'(HD * VD));
    enable = 1'b0;
    send_frame(VD, -1, -1, -1, -1, 1'b0);
    check("t6_frame_cnt", 31'(fcnt0), 31'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
